tlp_tx_encoder: RTL and testbench
=================================

Name: tlp_tx_encoder

Overview:
- Downstream of the application-to-TL TX bridge: takes one registered TLP request (header fields plus indexed payload) and serializes it onto a 32-bit DW stream toward the TX buffer/DLL.
- Owns the bridge handshake: `fsm_started` and `fsm_finished` pulses out, `data_address` out to read the bridge's payload file.
- Builds 3DW/4DW headers for memory, IO, message, completion and config requests, then streams the payload under `tlp_ready` backpressure.

Parameters:
- MAX_PAYLOAD_DW, 3, payload length saturation (matches the bridge's data-file depth).
- ADDR_W, 10, width of `data_address`.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  request pending (bridge valid_reg)
- fmt  in  3  TLP fmt; bit1 = data present, bit0 = 4DW header
- type_  in  5  TLP type
- TC  in  3  traffic class
- ATTR  in  3  attributes
- device_id  in  16  completer ID (completions)
- requester_id  in  16  requester ID
- tag  in  8  tag
- byte_count  in  12  byte count
- lower_addr  in  32  address low / completion lower address
- upper_addr  in  32  address high
- dest_bdf_id  in  16  config target BDF
- config_dw_number  in  10  config register DW number
- completion_status  in  3  completion status
- message_code  in  8  message code
- data_in  in  32  payload DW at `data_address`, combinational from bridge
- data_address  out  ADDR_W  payload index
- fsm_started  out  1  1-cycle pulse, request accepted
- fsm_finished  out  1  1-cycle pulse, encoder free
- tlp_dw  out  32  stream data
- tlp_valid  out  1  stream valid
- tlp_sop  out  1  first DW of TLP
- tlp_eop  out  1  last DW of TLP
- tlp_ready  in  1  downstream accept

Behaviour:
- **Reset:** while `rst`=1, all outputs are 0 and state is IDLE. The first cycle after `rst` falls, `fsm_finished`=1 for one cycle (announce pulse, primes the bridge). Reset mid-TLP aborts it with no eop; the announce pulse repeats after release.
- **States:** IDLE, HDR, DATA, DONE.
- **IDLE:** if `in_valid`, capture all inputs into shadow registers at the edge, go to HDR. `fsm_started`=1 during the first HDR cycle only.
- **Output register:** loads a new DW when `!tlp_valid || tlp_ready`; otherwise `tlp_dw`, `tlp_sop` and `tlp_eop` hold stable.
- **Latency:** `in_valid` sampled at edge N; DW0 is presented at cycle N+2.
- **Length:**
  - `len = (byte_count+3)>>2`.
  - If 0, use 1. If above MAX_PAYLOAD_DW, saturate to MAX_PAYLOAD_DW.
  - The length field carries `len` for reads too.
- **Header size:** 4 DW if `fmt[0]`, else 3 DW.
- **DW0:** {fmt, type_, 1'b0, TC, 1'b0, ATTR[2], 4'b0, ATTR[1:0], 2'b00, len[9:0]}.
- **DW1:**
  - Completion (type_=01010): {device_id, completion_status, 1'b0, byte_count}.
  - Message (type_[4:3]=10): {requester_id, tag, message_code}.
  - Otherwise: {requester_id, tag, lastBE, 4'hF}, where lastBE = 0 if `len`=1, else F.
- **DW2/DW3:**
  - Completion: DW2 = {requester_id, tag, 1'b0, lower_addr[6:0]}.
  - Config (type_[4:1]=0010): DW2 = {dest_bdf_id, 4'b0, config_dw_number, 2'b00}.
  - 4DW header: DW2 = upper_addr, DW3 = {lower_addr[31:2], 2'b00}.
  - Otherwise: DW2 = {lower_addr[31:2], 2'b00}.
- **DATA:** entered only if `fmt[1]`.
  - `data_address` runs 0..len-1, advancing only when a payload DW is loaded into the output register.
  - `data_address` is 0 outside DATA.
- **Markers:** `tlp_sop` only on DW0. `tlp_eop` on the last header DW if no data, else on the last payload DW.
- **DONE:** entered when the eop DW is accepted (`tlp_valid && tlp_ready && tlp_eop`). Assert `fsm_finished` for one cycle, then IDLE.
- **No re-start:** IDLE does not restart in the DONE cycle. `in_valid` is only sampled in IDLE.
- **Shadow registers:** inputs changing after capture have no effect on the TLP in flight.

Test Plan:
- **MRd32:** fmt=000 type_=00000 requester_id=0x0100 tag=0x05 lower_addr=0x10000004 byte_count=4, `tlp_ready`=1 → DW0=0x00000001 (sop), DW1=0x0100050F, DW2=0x10000004 (eop). `fsm_started` at N+1, DW0 at N+2, `fsm_finished` one cycle after eop accept.
- **MWr64 with data:** fmt=011 byte_count=8 upper_addr=0x1 lower_addr=0x20000000 tag=0x06, data 0xAAAAAAAA/0xBBBBBBBB → DW0=0x60000002, DW1=0x010006FF, DW2=0x00000001, DW3=0x20000000, DW4=0xAAAAAAAA (`data_address`=0), DW5=0xBBBBBBBB (`data_address`=1, eop).
- **CplD:** fmt=010 type_=01010 device_id=0x0200 status=0 byte_count=4 requester_id=0x0100 tag=0x07 lower_addr=0x44 → DW0=0x4A000001, DW1=0x02000004, DW2=0x01000744, then payload DW.
- **CfgWr0:** fmt=010 type_=00100 dest_bdf_id=0x0300 config_dw_number=4 → DW0=0x44000001, DW2=0x03000010. Also byte_count=20 on a MWr → length field=3, exactly 3 payload DWs.
- **Backpressure:** `tlp_ready` low for 3 cycles on DW1 → DW1, sop and eop held stable; `data_address` does not advance; no DW dropped or duplicated.
- **Reset:** assert `rst` during DATA → outputs 0 immediately; after release, `fsm_finished` pulses once and a new `in_valid` is encoded correctly.

Source files
------------

// File: rtl/tlp_tx_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlp_tx_encoder_if : bridge request, payload file and DW stream bundle |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface tlp_tx_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [2:0]        fmt;
  logic [4:0]        type_;
  logic [2:0]        TC;
  logic [2:0]        ATTR;
  logic [15:0]       device_id;
  logic [15:0]       requester_id;
  logic [7:0]        tag;
  logic [11:0]       byte_count;
  logic [31:0]       lower_addr;
  logic [31:0]       upper_addr;
  logic [15:0]       dest_bdf_id;
  logic [9:0]        config_dw_number;
  logic [2:0]        completion_status;
  logic [7:0]        message_code;
  logic [31:0]       data_in;
  logic [ADDR_W-1:0] data_address;
  logic              fsm_started;
  logic              fsm_finished;
  logic [31:0]       tlp_dw;
  logic              tlp_valid;
  logic              tlp_sop;
  logic              tlp_eop;
  logic              tlp_ready;

  modport master (
    output in_valid, fmt, type_, TC, ATTR, device_id, requester_id, tag,
           byte_count, lower_addr, upper_addr, dest_bdf_id, config_dw_number,
           completion_status, message_code, data_in, tlp_ready,
    input  data_address, fsm_started, fsm_finished, tlp_dw, tlp_valid,
           tlp_sop, tlp_eop
  );

  modport slave (
    input  in_valid, fmt, type_, TC, ATTR, device_id, requester_id, tag,
           byte_count, lower_addr, upper_addr, dest_bdf_id, config_dw_number,
           completion_status, message_code, data_in, tlp_ready,
    output data_address, fsm_started, fsm_finished, tlp_dw, tlp_valid,
           tlp_sop, tlp_eop
  );
endinterface
`default_nettype wire

// File: rtl/tlp_tx_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlp_tx_encoder : serializes one TLP request into a 32-bit DW stream   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tlp_tx_encoder #(
  parameter int MAX_PAYLOAD_DW = 3,
  parameter int ADDR_W         = 10
) (
  input  wire logic         clk,
  input  wire logic         rst,
  tlp_tx_encoder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic              boot_q;
  logic              started_q;
  logic              finished_q;
  logic [31:0]       tlp_dw_q;
  logic              valid_q;
  logic              sop_q;
  logic              eop_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        idx_q;
  logic              all_q;

  logic [2:0]  fmt_q;
  logic [4:0]  type_q;
  logic [2:0]  tc_q;
  logic [2:0]  attr_q;
  logic [15:0] dev_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [11:0] bc_q;
  logic [31:0] lo_q;
  logic [31:0] up_q;
  logic [15:0] bdf_q;
  logic [9:0]  cfg_q;
  logic [2:0]  cst_q;
  logic [7:0]  msg_q;

  logic [10:0] len_raw_d;
  logic [10:0] len_d;
  logic [3:0]  last_be_d;
  logic        is_cpl_d;
  logic        is_msg_d;
  logic        is_cfg_d;
  logic        hdr_last_d;
  logic        pay_last_d;
  logic        load_en_d;
  logic [31:0] hdr_dw_d;

  always_comb begin
    len_raw_d = 11'(({1'b0, bc_q} + 13'd3) >> 2);
    if (len_raw_d == 11'd0) begin
      len_d = 11'd1;
    end else if (len_raw_d > 11'(MAX_PAYLOAD_DW)) begin
      len_d = 11'(MAX_PAYLOAD_DW);
    end else begin
      len_d = len_raw_d;
    end
    last_be_d  = (len_d == 11'd1) ? 4'h0 : 4'hF;
    is_cpl_d   = (type_q == 5'b01010);
    is_msg_d   = (type_q[4:3] == 2'b10);
    is_cfg_d   = (type_q[4:1] == 4'b0010);
    hdr_last_d = (idx_q == (fmt_q[0] ? 2'd3 : 2'd2));
    pay_last_d = (addr_q == ADDR_W'(len_d - 11'd1));
    load_en_d  = !valid_q || bus.tlp_ready;
  end

  // Header DW selected by position; completion/config override the address words.
  always_comb begin
    hdr_dw_d = 32'h0;
    case (idx_q)
      2'd0: hdr_dw_d = {fmt_q, type_q, 1'b0, tc_q, 1'b0, attr_q[2], 4'b0000,
                        attr_q[1:0], 2'b00, len_d[9:0]};
      2'd1: begin
        if (is_cpl_d) begin
          hdr_dw_d = {dev_q, cst_q, 1'b0, bc_q};
        end else if (is_msg_d) begin
          hdr_dw_d = {rid_q, tag_q, msg_q};
        end else begin
          hdr_dw_d = {rid_q, tag_q, last_be_d, 4'hF};
        end
      end
      2'd2: begin
        if (is_cpl_d) begin
          hdr_dw_d = {rid_q, tag_q, 1'b0, lo_q[6:0]};
        end else if (is_cfg_d) begin
          hdr_dw_d = {bdf_q, 4'b0000, cfg_q, 2'b00};
        end else if (fmt_q[0]) begin
          hdr_dw_d = up_q;
        end else begin
          hdr_dw_d = {lo_q[31:2], 2'b00};
        end
      end
      default: hdr_dw_d = {lo_q[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      boot_q     <= 1'b1;
      started_q  <= 1'b0;
      finished_q <= 1'b0;
      tlp_dw_q   <= 32'h0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      addr_q     <= '0;
      idx_q      <= 2'd0;
      all_q      <= 1'b0;
      fmt_q      <= '0;
      type_q     <= '0;
      tc_q       <= '0;
      attr_q     <= '0;
      dev_q      <= '0;
      rid_q      <= '0;
      tag_q      <= '0;
      bc_q       <= '0;
      lo_q       <= '0;
      up_q       <= '0;
      bdf_q      <= '0;
      cfg_q      <= '0;
      cst_q      <= '0;
      msg_q      <= '0;
    end else begin
      started_q  <= 1'b0;
      // boot_q turns the first post-reset cycle into the announce pulse
      finished_q <= boot_q;
      boot_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            fmt_q     <= bus.fmt;
            type_q    <= bus.type_;
            tc_q      <= bus.TC;
            attr_q    <= bus.ATTR;
            dev_q     <= bus.device_id;
            rid_q     <= bus.requester_id;
            tag_q     <= bus.tag;
            bc_q      <= bus.byte_count;
            lo_q      <= bus.lower_addr;
            up_q      <= bus.upper_addr;
            bdf_q     <= bus.dest_bdf_id;
            cfg_q     <= bus.config_dw_number;
            cst_q     <= bus.completion_status;
            msg_q     <= bus.message_code;
            idx_q     <= 2'd0;
            all_q     <= 1'b0;
            addr_q    <= '0;
            started_q <= 1'b1;
            state_q   <= S_HDR;
          end
        end
        S_HDR, S_DATA: begin
          if (valid_q && bus.tlp_ready && eop_q) begin
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            addr_q     <= '0;
            all_q      <= 1'b0;
            finished_q <= 1'b1;
            state_q    <= S_DONE;
          end else if (load_en_d && !all_q) begin
            valid_q <= 1'b1;
            if (state_q == S_HDR) begin
              tlp_dw_q <= hdr_dw_d;
              sop_q    <= (idx_q == 2'd0);
              eop_q    <= hdr_last_d && !fmt_q[1];
              if (hdr_last_d) begin
                idx_q <= 2'd0;
                if (fmt_q[1]) begin
                  state_q <= S_DATA;
                end else begin
                  all_q <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end else begin
              // Address is held on the last payload DW until the TLP completes
              tlp_dw_q <= bus.data_in;
              sop_q    <= 1'b0;
              eop_q    <= pay_last_d;
              if (pay_last_d) begin
                all_q <= 1'b1;
              end else begin
                addr_q <= addr_q + 1'b1;
              end
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.data_address = addr_q;
  assign bus.fsm_started  = started_q;
  assign bus.fsm_finished = finished_q;
  assign bus.tlp_dw       = tlp_dw_q;
  assign bus.tlp_valid    = valid_q;
  assign bus.tlp_sop      = sop_q;
  assign bus.tlp_eop      = eop_q;

endmodule
`default_nettype wire

// File: tb/tb_tlp_tx_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tlp_tx_encoder : vector table + scoreboard bench for the encoder   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_tlp_tx_encoder;
  localparam int ADDR_W = 10;
  localparam int NV     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlp_tx_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  tlp_tx_encoder #(.MAX_PAYLOAD_DW(3), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0]       fmt;
    logic [4:0]       typ;
    logic [2:0]       tc;
    logic [2:0]       attr;
    logic [15:0]      dev;
    logic [15:0]      rid;
    logic [7:0]       tag;
    logic [11:0]      bc;
    logic [31:0]      lo;
    logic [31:0]      up;
    logic [15:0]      bdf;
    logic [9:0]       cfg;
    logic [2:0]       st;
    logic [7:0]       msg;
    logic [3:0]       n;
    logic [3:0]       nd;
    logic [8:0][31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] dw;
    logic        sop;
    logic        eop;
    logic        hdr;
  } beat_t;

  vec_t  v [0:NV-1];
  beat_t sbq [$];
  logic [31:0] pay [0:3];
  int n_chk = 0;
  int n_pass = 0;
  int started_cnt = 0;

  assign bus.data_in = (bus.data_address < ADDR_W'(4)) ? pay[bus.data_address[1:0]] : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Stream monitor: stall stability and in-order scoreboard compare
  logic              stall_prev = 1'b0;
  logic [31:0]       prev_dw;
  logic              prev_sop, prev_eop;
  logic [ADDR_W-1:0] prev_addr;
  beat_t             b;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.fsm_started) started_cnt++;
      if (stall_prev) begin
        chk("hold valid", 32'(bus.tlp_valid), 32'd1);
        chk("hold dw", bus.tlp_dw, prev_dw);
        chk("hold sop", 32'(bus.tlp_sop), 32'(prev_sop));
        chk("hold eop", 32'(bus.tlp_eop), 32'(prev_eop));
        chk("hold addr", 32'(bus.data_address), 32'(prev_addr));
      end
      if (bus.tlp_valid && bus.tlp_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected beat: got %h, expected none", bus.tlp_dw);
        end else begin
          b = sbq.pop_front();
          chk("beat dw", bus.tlp_dw, b.dw);
          chk("beat sop", 32'(bus.tlp_sop), 32'(b.sop));
          chk("beat eop", 32'(bus.tlp_eop), 32'(b.eop));
          if (b.hdr) chk("hdr addr", 32'(bus.data_address), 32'd0);
        end
      end
      stall_prev = bus.tlp_valid && !bus.tlp_ready;
      prev_dw    = bus.tlp_dw;
      prev_sop   = bus.tlp_sop;
      prev_eop   = bus.tlp_eop;
      prev_addr  = bus.data_address;
    end
  end

  task automatic drive_fields(input vec_t t);
    bus.fmt = t.fmt; bus.type_ = t.typ; bus.TC = t.tc; bus.ATTR = t.attr;
    bus.device_id = t.dev; bus.requester_id = t.rid; bus.tag = t.tag;
    bus.byte_count = t.bc; bus.lower_addr = t.lo; bus.upper_addr = t.up;
    bus.dest_bdf_id = t.bdf; bus.config_dw_number = t.cfg;
    bus.completion_status = t.st; bus.message_code = t.msg;
  endtask

  // Returns just after the capture edge; fields are scrambled afterwards.
  task automatic issue(input vec_t t);
    int base;
    vec_t junk;
    base = int'(t.n) - int'(t.nd);
    @(posedge clk); #1;
    drive_fields(t);
    for (int i = 0; i < int'(t.nd); i++) pay[i] = t.exp[base + i];
    for (int i = 0; i < int'(t.n); i++)
      sbq.push_back('{dw: t.exp[i], sop: (i == 0), eop: (i == int'(t.n) - 1), hdr: (i < base)});
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    junk = vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    drive_fields(junk);
  endtask

  task automatic wait_done(input string name, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.fsm_finished) seen = 1'b1;
      else if (rnd) bus.tlp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.tlp_ready = 1'b1;
    chk({name, " finished"}, 32'(seen), 32'd1);
    chk({name, " drained"}, 32'(sbq.size()), 32'd0);
    chk({name, " idle valid"}, 32'(bus.tlp_valid), 32'd0);
    chk({name, " idle addr"}, 32'(bus.data_address), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " valid"}, 32'(bus.tlp_valid), 32'd0);
    chk({name, " sop"}, 32'(bus.tlp_sop), 32'd0);
    chk({name, " eop"}, 32'(bus.tlp_eop), 32'd0);
    chk({name, " dw"}, bus.tlp_dw, 32'd0);
    chk({name, " started"}, 32'(bus.fsm_started), 32'd0);
    chk({name, " finished"}, 32'(bus.fsm_finished), 32'd0);
    chk({name, " addr"}, 32'(bus.data_address), 32'd0);
  endtask

  initial begin
    int st0;
    bit found;
    for (int i = 0; i < NV; i++) v[i] = '0;
    // MRd32
    v[0].rid = 16'h0100; v[0].tag = 8'h05; v[0].lo = 32'h10000004; v[0].bc = 12'd4; v[0].n = 4'd3;
    v[0].exp[0] = 32'h00000001; v[0].exp[1] = 32'h0100050F; v[0].exp[2] = 32'h10000004;
    // MWr64 with two payload DWs
    v[1].fmt = 3'b011; v[1].rid = 16'h0100; v[1].tag = 8'h06; v[1].bc = 12'd8;
    v[1].up = 32'h1; v[1].lo = 32'h20000000; v[1].n = 4'd6; v[1].nd = 4'd2;
    v[1].exp[0] = 32'h60000002; v[1].exp[1] = 32'h010006FF; v[1].exp[2] = 32'h00000001;
    v[1].exp[3] = 32'h20000000; v[1].exp[4] = 32'hAAAAAAAA; v[1].exp[5] = 32'hBBBBBBBB;
    // CplD
    v[2].fmt = 3'b010; v[2].typ = 5'b01010; v[2].dev = 16'h0200; v[2].bc = 12'd4;
    v[2].rid = 16'h0100; v[2].tag = 8'h07; v[2].lo = 32'h44; v[2].n = 4'd4; v[2].nd = 4'd1;
    v[2].exp[0] = 32'h4A000001; v[2].exp[1] = 32'h02000004; v[2].exp[2] = 32'h01000744;
    v[2].exp[3] = 32'hCCCCCCCC;
    // CfgWr0
    v[3].fmt = 3'b010; v[3].typ = 5'b00100; v[3].rid = 16'h0100; v[3].tag = 8'h08;
    v[3].bdf = 16'h0300; v[3].cfg = 10'd4; v[3].bc = 12'd4; v[3].n = 4'd4; v[3].nd = 4'd1;
    v[3].exp[0] = 32'h44000001; v[3].exp[1] = 32'h0100080F; v[3].exp[2] = 32'h03000010;
    v[3].exp[3] = 32'h12345678;
    // MWr32, byte_count 20 saturates to 3 DWs
    v[4].fmt = 3'b010; v[4].rid = 16'h0100; v[4].tag = 8'h09; v[4].bc = 12'd20;
    v[4].lo = 32'h30000008; v[4].n = 4'd6; v[4].nd = 4'd3;
    v[4].exp[0] = 32'h40000003; v[4].exp[1] = 32'h010009FF; v[4].exp[2] = 32'h30000008;
    v[4].exp[3] = 32'h11111111; v[4].exp[4] = 32'h22222222; v[4].exp[5] = 32'h33333333;
    // MRd32, byte_count 0 -> length 1, TC/ATTR fields, low address bits dropped
    v[5].tc = 3'd5; v[5].attr = 3'd7; v[5].rid = 16'h0200; v[5].tag = 8'h0A;
    v[5].lo = 32'h00000ABF; v[5].n = 4'd3;
    v[5].exp[0] = 32'h00543001; v[5].exp[1] = 32'h02000A0F; v[5].exp[2] = 32'h00000ABC;
    // Message, 4DW header, no data
    v[6].fmt = 3'b001; v[6].typ = 5'b10000; v[6].rid = 16'h0300; v[6].tag = 8'h0B;
    v[6].msg = 8'h7F; v[6].bc = 12'd4; v[6].up = 32'h12345678; v[6].lo = 32'h9ABCDEF3; v[6].n = 4'd4;
    v[6].exp[0] = 32'h30000001; v[6].exp[1] = 32'h03000B7F; v[6].exp[2] = 32'h12345678;
    v[6].exp[3] = 32'h9ABCDEF0;
    // Cpl without data, status 2, length saturates
    v[7].typ = 5'b01010; v[7].dev = 16'h0400; v[7].st = 3'd2; v[7].bc = 12'h0FF;
    v[7].rid = 16'h0500; v[7].tag = 8'h0C; v[7].lo = 32'h7F; v[7].n = 4'd3;
    v[7].exp[0] = 32'h0A000003; v[7].exp[1] = 32'h040040FF; v[7].exp[2] = 32'h05000C7F;

    bus.in_valid = 1'b0;
    bus.tlp_ready = 1'b1;
    drive_fields(v[0]);
    for (int i = 0; i < 4; i++) pay[i] = 32'h0;

    // Reset state and post-reset announce pulse
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 chk("announce on", 32'(bus.fsm_finished), 32'd1);
    @(posedge clk); #1 chk("announce off", 32'(bus.fsm_finished), 32'd0);

    // MRd32 cycle-exact timing with ready held high
    st0 = started_cnt;
    issue(v[0]);
    chk("started N+1", 32'(bus.fsm_started), 32'd1);
    chk("no dw N+1", 32'(bus.tlp_valid), 32'd0);
    @(posedge clk); #1;
    chk("started off", 32'(bus.fsm_started), 32'd0);
    chk("dw0 valid N+2", 32'(bus.tlp_valid), 32'd1);
    chk("dw0 sop N+2", 32'(bus.tlp_sop), 32'd1);
    chk("dw0 N+2", bus.tlp_dw, 32'h00000001);
    repeat (2) @(posedge clk);
    #1 chk("eop shown", 32'(bus.tlp_eop), 32'd1);
    chk("no early finish", 32'(bus.fsm_finished), 32'd0);
    @(posedge clk); #1 chk("finish after eop", 32'(bus.fsm_finished), 32'd1);
    chk("mrd drained", 32'(sbq.size()), 32'd0);
    chk("mrd one start", 32'(started_cnt - st0), 32'd1);

    // Table vectors under random backpressure
    for (int i = 0; i < NV; i++) begin
      st0 = started_cnt;
      issue(v[i]);
      wait_done($sformatf("vec%0d", i), 1'b1);
      chk($sformatf("vec%0d one start", i), 32'(started_cnt - st0), 32'd1);
    end

    // DW1 held for three cycles of backpressure
    bus.tlp_ready = 1'b1;
    issue(v[1]);
    @(posedge clk); #1 chk("bp dw0", bus.tlp_dw, 32'h60000002);
    @(posedge clk); #1 bus.tlp_ready = 1'b0;
    chk("bp dw1 shown", bus.tlp_dw, 32'h010006FF);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp dw1 held", bus.tlp_dw, 32'h010006FF);
      chk("bp sop held", 32'(bus.tlp_sop), 32'd0);
      chk("bp addr held", 32'(bus.data_address), 32'd0);
    end
    bus.tlp_ready = 1'b1;
    wait_done("bp", 1'b0);

    // Reset in the middle of the payload
    issue(v[4]);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      if (bus.tlp_valid && bus.tlp_dw == 32'h11111111) found = 1'b1;
    end
    chk("reach payload", 32'(found), 32'd1);
    rst = 1'b1;
    #1 chk_all_zero("mid reset");
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 chk("re-announce on", 32'(bus.fsm_finished), 32'd1);
    @(posedge clk); #1 chk("re-announce off", 32'(bus.fsm_finished), 32'd0);
    issue(v[2]);
    wait_done("after reset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
